// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences start-up, then drives the load
// enables and bubble flushes of a 5-stage pipeline from dmem, branch,
// load-use and imem hazards (priority in that order).
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN enables the stall/flush
// performance counters; without it both counter ports are tied to 0.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        dmem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, MEM_WAIT} state_t;

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       load_use;
  logic       run_rules;

  // A load in EX whose destination feeds an operand the ID instruction reads;
  // x0 is hard-wired zero and never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State and dmem wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state and combinational decode of enables/flushes
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    run_rules     = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    dmem_timeout  = 1'b0;

    case (state_reg)
      IDLE: begin
        wait_cnt_next = 8'd0;
        state_next    = INIT;
      end
      INIT: begin
        // Bubble every pipeline register once; a flush needs its enable too.
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        state_next   = RUN;
      end
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          mem_wb_en     = 1'b1;
          mem_wb_flush  = 1'b1;
          wait_cnt_next = 8'd1;
          state_next    = MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // Memory answered: this cycle already behaves as a normal RUN cycle.
          run_rules     = 1'b1;
          wait_cnt_next = 8'd0;
          state_next    = RUN;
        end else begin
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
          if (wait_cnt_reg == 8'(MAX_WAIT)) begin
            // Give up: kill the stuck access in EX/MEM and resume.
            dmem_timeout  = 1'b1;
            ex_mem_en     = 1'b1;
            ex_mem_flush  = 1'b1;
            wait_cnt_next = 8'd0;
            state_next    = RUN;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase

    if (run_rules) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;
  logic        active;

  assign active = (state_reg == RUN) || (state_reg == MEM_WAIT);

  // Performance counters: frozen-PC cycles and branch redirects (wrap freely)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (active && !pc_en)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      // Only a branch redirect flushes IF/ID and ID/EX while the PC advances.
      if (active && pc_en && if_id_flush && id_ex_flush)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum dmem wait cycles before timeout (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  ID-stage source register indices.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-006 SHALL have ports ex_mem_read  input  1 and ex_rd  input  5  EX-stage instruction is a load and its destination.
REQ-007 SHALL have port branch_taken  input  1  EX-stage redirect (branch/jump resolved taken).
REQ-008 SHALL have ports imem_ready  input  1, dmem_req  input  1, dmem_ready  input  1  memory handshakes.
REQ-009 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  1 each  pipeline register load enables.
REQ-010 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  1 each  load bubble (all-zero) into register.
REQ-011 SHALL have output dmem_timeout  1  one-cycle error pulse; outputs stall_cnt, flush_cnt  32 each  performance counters.

Function
REQ-012 SHALL implement states IDLE, INIT, RUN, MEM_WAIT; outputs are combinational decode of state and inputs.
REQ-013 IDLE: all enables 0, all flushes 0; unconditional transition to INIT.
REQ-014 INIT (one cycle): all flushes 1, pc_en 0; transition to RUN.
REQ-015 RUN default: all enables 1, all flushes 0.
REQ-016 RUN, dmem_req=1 and dmem_ready=0: all enables 0 except mem_wb_en=1 with mem_wb_flush=1; go to MEM_WAIT, wait counter <= 1.
REQ-017 MEM_WAIT: same outputs as REQ-016; dmem_ready=1 -> RUN with that cycle's outputs per RUN rules; else counter increments.
REQ-018 MEM_WAIT with counter==MAX_WAIT and dmem_ready=0: dmem_timeout=1 for that cycle, ex_mem_flush=1, ex_mem_en=1, go to RUN.
REQ-019 RUN, branch_taken=1 (no dmem stall): if_id_flush=1, id_ex_flush=1, pc_en=1; load-use ignored that cycle.
REQ-020 RUN, load-use (ex_mem_read, ex_rd!=0, and matching used id_rs1/id_rs2), no branch/dmem stall: pc_en=0, if_id_en=0, id_ex_flush=1.
REQ-021 RUN, imem_ready=0 with no higher-priority event: pc_en=0, if_id_flush=1, later stages advance.
REQ-022 Priority SHALL be dmem stall > branch flush > load-use > imem stall.
REQ-023 ex_rd==0 SHALL never raise load-use hazard.
REQ-024 A flushed register SHALL also have its enable asserted in the same cycle.

Reset
REQ-025 rst_n low SHALL force state IDLE, wait counter 0, stall_cnt/flush_cnt 0, dmem_timeout 0, asynchronously.
REQ-026 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no timeout pulse.

Configuration
REQ-027 With PIPE_HAZARD_CTRL_PERF_EN defined: stall_cnt increments each cycle pc_en=0 in RUN/MEM_WAIT, flush_cnt increments each branch flush; both wrap at 2^32.
REQ-028 Without PIPE_HAZARD_CTRL_PERF_EN: stall_cnt and flush_cnt ports exist, driven constant 0, no counter flops.

Verification
REQ-029 Release reset -> IDLE 1 cycle, INIT 1 cycle (all flushes 1), then RUN with all enables 1.
REQ-030 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 one cycle; ex_rd=0 same -> no stall.
REQ-031 branch_taken=1 simultaneous with load-use -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt +1 with PERF_EN.
REQ-032 dmem_req=1, dmem_ready low 3 cycles -> 3 freeze cycles, mem_wb_flush=1, resume on 4th; stall_cnt +3.
REQ-033 MAX_WAIT=4, dmem_ready never high -> dmem_timeout pulse on 4th MEM_WAIT cycle with ex_mem_flush=1, then RUN.
REQ-034 rst_n low during MEM_WAIT -> IDLE immediately, counters 0, no timeout pulse.
